if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the LEGv8 5-stage pipeline, and the producer side of the decode stage's instruction interface.
- Owns the PC register and the IF/ID pipeline register.
- Drives the instruction memory address and delivers Instruction, PC and a valid flag to decode.
- Accepts stall from the hazard unit, and IF_Flush plus branch redirect from decode.

---
 rtl/if_fetch_stage.sv | 91 +++++++++
 tb/tb_if_fetch_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: LEGv8 instruction-fetch stage owning the PC and the IF/ID register.
// Optional perf counters (fetch/stall/flush) are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          PC_STEP   = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 IF_Flush,
    input  logic                 branch_taken,
    input  logic [63:0]          branch_target,
    input  logic [31:0]          imem_rdata,
    output logic [63:0]          imem_addr,
    output logic [31:0]          Instruction,
    output logic [63:0]          PC_ID,
    output logic                 valid_ID,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_id_q, pc_id_d;
    logic        valid_q, valid_d;
    logic        load;

    // Next-state: redirect beats stall for the PC, flush beats stall for IF/ID.
    always_comb begin
        load    = !IF_Flush && !stall;
        pc_d    = branch_taken ? {branch_target[63:2], 2'b00} : stall ? pc_q : pc_q + 64'(PC_STEP);
        instr_d = IF_Flush ? NOP_INSTR : load ? imem_rdata : instr_q;
        pc_id_d = IF_Flush ? 64'h0 : load ? pc_q : pc_id_q;
        valid_d = IF_Flush ? 1'b0 : load ? 1'b1 : valid_q;
    end

    // PC and IF/ID registers; reset inserts a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc_id_q <= 64'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign PC_ID       = pc_id_q;
    assign valid_ID    = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] fetch_q, stall_q, flush_q;
    logic [CNT_WIDTH-1:0] fetch_d, stall_d, flush_d;

    // Saturating increments; each counter sticks at all-ones.
    always_comb begin
        fetch_d = fetch_q + CNT_WIDTH'(load && !(&fetch_q));
        stall_d = stall_q + CNT_WIDTH'(stall && !IF_Flush && !(&stall_q));
        flush_d = flush_q + CNT_WIDTH'(IF_Flush && !(&flush_q));
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign fetch_count = fetch_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall = 1'b0;
    logic        IF_Flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] imem_rdata;
    logic [63:0] imem_addr;
    logic [31:0] Instruction;
    logic [63:0] PC_ID;
    logic        valid_ID;
    logic [31:0] fetch_count, stall_count, flush_count;
    int          n_tests = 0;
    int          n_fail = 0;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .IF_Flush(IF_Flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .Instruction(Instruction),
        .PC_ID(PC_ID), .valid_ID(valid_ID), .fetch_count(fetch_count),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr[31:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [63:0] addr, input logic [31:0] ins,
                          input logic [63:0] pcid, input logic v);
        chk({tag, ".imem_addr"}, imem_addr, addr);
        chk({tag, ".Instruction"}, {32'h0, Instruction}, {32'h0, ins});
        chk({tag, ".PC_ID"}, PC_ID, pcid);
        chk({tag, ".valid_ID"}, {63'h0, valid_ID}, {63'h0, v});
    endtask

    task automatic chk_cnt(input string tag, input int f, input int s, input int fl);
`ifdef IF_PERF_CNT_EN
        chk({tag, ".fetch_count"}, {32'h0, fetch_count}, 64'(f));
        chk({tag, ".stall_count"}, {32'h0, stall_count}, 64'(s));
        chk({tag, ".flush_count"}, {32'h0, flush_count}, 64'(fl));
`else
        chk({tag, ".fetch_count"}, {32'h0, fetch_count}, 64'h0);
        chk({tag, ".stall_count"}, {32'h0, stall_count}, 64'h0);
        chk({tag, ".flush_count"}, {32'h0, flush_count}, 64'h0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        chk_if("reset", 64'h0, 32'h0, 64'h0, 1'b0);
        chk_cnt("reset", 0, 0, 0);
        reset = 1'b0;
        // Sequential fetch from RESET_PC.
        tick(); chk_if("seq0", 64'h4,  32'h0, 64'h0, 1'b1);
        tick(); chk_if("seq1", 64'h8,  32'h4, 64'h4, 1'b1);
        tick(); chk_if("seq2", 64'hC,  32'h8, 64'h8, 1'b1);
        tick(); chk_if("seq3", 64'h10, 32'hC, 64'hC, 1'b1);
        // Taken branch with flush at PC=0x10.
        branch_taken = 1'b1; IF_Flush = 1'b1; branch_target = 64'h40;
        tick(); chk_if("br_bubble", 64'h40, 32'h0, 64'h0, 1'b0);
        branch_taken = 1'b0; IF_Flush = 1'b0;
        tick(); chk_if("br_target", 64'h44, 32'h40, 64'h40, 1'b1);
        // Redirect without flush: the fetched word still enters IF/ID.
        branch_taken = 1'b1; branch_target = 64'h20;
        tick(); chk_if("br_noflush", 64'h20, 32'h44, 64'h44, 1'b1);
        branch_taken = 1'b0;
        // Stall three edges at PC=0x20.
        stall = 1'b1;
        tick(); chk_if("stall1", 64'h20, 32'h44, 64'h44, 1'b1);
        tick(); chk_if("stall2", 64'h20, 32'h44, 64'h44, 1'b1);
        tick(); chk_if("stall3", 64'h20, 32'h44, 64'h44, 1'b1);
        stall = 1'b0;
        tick(); chk_if("unstall", 64'h24, 32'h20, 64'h20, 1'b1);
        chk_cnt("after_stall", 7, 3, 1);
        // Stall + flush + redirect with misaligned target.
        stall = 1'b1; IF_Flush = 1'b1; branch_taken = 1'b1; branch_target = 64'h103;
        tick(); chk_if("combo", 64'h100, 32'h0, 64'h0, 1'b0);
        chk_cnt("combo", 7, 3, 2);
        stall = 1'b0; IF_Flush = 1'b0; branch_taken = 1'b0;
        // Move to PC=0x88 then assert reset between edges.
        branch_taken = 1'b1; branch_target = 64'h88;
        tick(); chk_if("to88", 64'h88, 32'h100, 64'h100, 1'b1);
        branch_taken = 1'b0;
        #3 reset = 1'b1;
        #1 chk_if("async_rst", 64'h0, 32'h0, 64'h0, 1'b0);
        chk_cnt("async_rst", 0, 0, 0);
        #2 reset = 1'b0;
        tick(); chk_if("post_rst", 64'h4, 32'h0, 64'h0, 1'b1);
        // Wrap-around of the PC.
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); chk("wrap_pre.imem_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        branch_taken = 1'b0;
        tick(); chk_if("wrap", 64'h0, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
